// File: rtl/msrv32_imem_responder.sv
// Instruction-memory responder for the msrv32 fetch path.
// Accepts a fetch address while idle, waits a fixed number of cycles, then
// presents the addressed word (or a NOP with a fault flag) for one cycle.
// A separate load port fills the word array and is independent of the FSM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a new fetch, request accepted on the next edge
// ST_WAIT | address latched, counting wait states down to the capture edge
// ST_RESP | captured word/fault presented, instr_valid_out high
module msrv32_imem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] IMEM_BASE   = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] imaddr_in,
    input  logic        imreq_in,
    output logic        imready_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic        imfault_out,
    input  logic        load_en_in,
    input  logic [31:0] load_addr_in,
    input  logic [31:0] load_data_in
);

    localparam int unsigned LP_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LP_WAIT = 4'(WAIT_STATES);
    localparam logic [31:0] LP_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        w_capture;

    logic [31:0] r_addr;
    logic [3:0]  r_cnt;
    logic [31:0] r_instr;
    logic        r_fault;

    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    // Word index is computed with a wrapping 32-bit subtraction, so addresses
    // below the base land far out of range rather than aliasing.
    logic [31:0]      w_fetch_word;
    logic [LP_AW-1:0] w_fetch_idx;
    logic             w_fetch_fault;
    logic [31:0]      w_load_word;
    logic [LP_AW-1:0] w_load_idx;
    logic             w_load_ok;

    assign w_fetch_word  = (r_addr - IMEM_BASE) >> 2;
    assign w_fetch_idx   = w_fetch_word[LP_AW-1:0];
    assign w_fetch_fault = (r_addr[1:0] != 2'b00) || (w_fetch_word >= DEPTH_WORDS);

    assign w_load_word   = (load_addr_in - IMEM_BASE) >> 2;
    assign w_load_idx    = w_load_word[LP_AW-1:0];
    assign w_load_ok     = (load_addr_in[1:0] == 2'b00) && (w_load_word < DEPTH_WORDS);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the accept/capture strobes used by the datapath.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (imreq_in) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address latch, wait-state down-counter and response capture.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_addr  <= 32'h0;
            r_cnt   <= 4'd0;
            r_instr <= 32'h0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= imaddr_in;
                r_cnt  <= LP_WAIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_instr <= w_fetch_fault ? LP_NOP : r_mem[w_fetch_idx];
                r_fault <= w_fetch_fault;
            end
        end
    end

    // Load port write; the array is deliberately left out of reset so that
    // its contents survive a reset pulse. Non-blocking update gives
    // read-before-write against a same-edge capture.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (load_en_in && w_load_ok) begin
            r_mem[w_load_idx] <= load_data_in;
        end
    end

    assign imready_out     = (r_state == ST_IDLE);
    assign instr_valid_out = (r_state == ST_RESP);
    assign instr_out       = r_instr;
    assign imfault_out     = r_fault;

endmodule

// File: tb/tb_msrv32_imem_responder.sv
// Directed bench for msrv32_imem_responder: a vector table of single fetches
// plus hand sequences for back-to-back fetches, load/capture collision,
// mid-transaction reset and a zero-wait-state instance.
module tb_msrv32_imem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] imaddr;
    logic        imreq;
    logic        ready;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic [31:0] z_imaddr;
    logic        z_imreq;
    logic        z_ready;
    logic [31:0] z_instr;
    logic        z_valid;
    logic        z_fault;
    logic        z_load_en;
    logic [31:0] z_load_addr;
    logic [31:0] z_load_data;

    int n_vec = 0;
    int n_bad = 0;

    msrv32_imem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .IMEM_BASE(32'h0)) u_dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .imaddr_in            (imaddr),
        .imreq_in             (imreq),
        .imready_out          (ready),
        .instr_out            (instr),
        .instr_valid_out      (valid),
        .imfault_out          (fault),
        .load_en_in           (load_en),
        .load_addr_in         (load_addr),
        .load_data_in         (load_data)
    );

    msrv32_imem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .IMEM_BASE(32'h0)) u_dut0 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .imaddr_in            (z_imaddr),
        .imreq_in             (z_imreq),
        .imready_out          (z_ready),
        .instr_out            (z_instr),
        .instr_valid_out      (z_valid),
        .imfault_out          (z_fault),
        .load_en_in           (z_load_en),
        .load_addr_in         (z_load_addr),
        .load_data_in         (z_load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    // Starts at #1 after an edge with the DUT idle; returns #1 after the
    // edge that raised instr_valid_out. lat counts edges after the accept edge.
    task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] ins,
                            output logic flt, output int rdy_bad);
        lat     = -1;
        ins     = 32'hx;
        flt     = 1'bx;
        rdy_bad = 0;
        imaddr  = a;
        imreq   = 1'b1;
        @(posedge clk); #1;
        imreq   = 1'b0;
        imaddr  = 32'h0000_0013;
        if (ready) rdy_bad++;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = n;
                ins = instr;
                flt = fault;
                break;
            end
            if (ready) rdy_bad++;
        end
    endtask

    int          lat;
    logic [31:0] ins;
    logic        flt;
    int          rdy_bad;
    int          k3;
    int          n_resp;
    int          cyc [3];
    logic [31:0] got [3];
    logic [31:0] seq_addr [3];
    int          pulses;

    initial begin
        vecs[0] = '{32'h0000_0130, 32'h00A0_0093, 1'b0};
        vecs[1] = '{32'h0000_0013, 32'h0000_0013, 1'b1};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[4] = '{32'h0000_0004, 32'h0000_0002, 1'b0};
        vecs[5] = '{32'h0000_0008, 32'h0000_0003, 1'b0};
        vecs[6] = '{32'h0000_03FC, 32'hCAFE_0001, 1'b0};
        vecs[7] = '{32'h0000_0400, 32'h0000_0013, 1'b1};
        vecs[8] = '{32'h0000_0002, 32'h0000_0013, 1'b1};

        rst = 1'b1;
        imaddr = 32'h0; imreq = 1'b0;
        load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
        z_imaddr = 32'h0; z_imreq = 1'b0;
        z_load_en = 1'b0; z_load_addr = 32'h0; z_load_data = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset instr", instr, 32'h0);
        chk("reset valid", 32'(valid), 32'h0);
        chk("reset fault", 32'(fault), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-reset ready", 32'(ready), 32'h1);
        chk("post-reset valid", 32'(valid), 32'h0);
        chk("dut0 post-reset ready", 32'(z_ready), 32'h1);

        load_word(32'h0000_0130, 32'h00A0_0093);
        load_word(32'h0000_0000, 32'h0000_0001);
        load_word(32'h0000_0004, 32'h0000_0002);
        load_word(32'h0000_0008, 32'h0000_0003);
        load_word(32'h0000_03FC, 32'hCAFE_0001);
        load_word(32'h0000_003C, 32'h1234_5678);
        // Both of these would alias word 0x130 if dropped-write checks were missing.
        load_word(32'h0000_0132, 32'h1111_1111);
        load_word(32'h0000_0530, 32'h2222_2222);

        for (int i = 0; i < 9; i++) begin
            do_fetch(vecs[i].addr, lat, ins, flt, rdy_bad);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d instr", i), ins, vecs[i].exp_instr);
            chk($sformatf("vec%0d fault", i), 32'(flt), 32'(vecs[i].exp_fault));
            chk($sformatf("vec%0d ready low while busy", i), 32'(rdy_bad), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid one cycle", i), 32'(valid), 32'h0);
            chk($sformatf("vec%0d instr hold", i), instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d ready again", i), 32'(ready), 32'h1);
        end

        // Held request, back-to-back fetches; address bus garbage while busy.
        seq_addr[0] = 32'h0; seq_addr[1] = 32'h4; seq_addr[2] = 32'h8;
        k3 = 0; n_resp = 0;
        for (int j = 0; j < 3; j++) begin
            cyc[j] = -100;
            got[j] = 32'hx;
        end
        for (int i = 0; i < 25; i++) begin
            if (valid) begin
                if (n_resp < 3) begin
                    cyc[n_resp] = i;
                    got[n_resp] = instr;
                end
                n_resp++;
            end
            if (ready) begin
                if (k3 < 3) begin
                    imaddr = seq_addr[k3];
                    imreq  = 1'b1;
                    k3++;
                end else begin
                    imreq = 1'b0;
                end
            end else begin
                imaddr = 32'h0000_0013;
            end
            @(posedge clk); #1;
        end
        imreq = 1'b0;
        chk("b2b response count", 32'(n_resp), 32'd3);
        chk("b2b first cycle", 32'(cyc[0]), 32'd4);
        chk("b2b spacing 1", 32'(cyc[1] - cyc[0]), 32'd5);
        chk("b2b spacing 2", 32'(cyc[2] - cyc[1]), 32'd5);
        chk("b2b resp0", got[0], 32'h1);
        chk("b2b resp1", got[1], 32'h2);
        chk("b2b resp2", got[2], 32'h3);

        // Load to the word being captured on the same edge.
        imaddr = 32'h8; imreq = 1'b1;
        @(posedge clk); #1;
        imreq = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        load_en = 1'b0;
        chk("collide valid", 32'(valid), 32'h1);
        chk("collide old word", instr, 32'h3);
        @(posedge clk); #1;
        do_fetch(32'h8, lat, ins, flt, rdy_bad);
        chk("refetch new word", ins, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Leave a fault captured so reset clearing of imfault_out is visible.
        do_fetch(32'h13, lat, ins, flt, rdy_bad);
        chk("pre-reset fault", 32'(flt), 32'h1);
        @(posedge clk); #1;

        // Reset one cycle after accepting a fetch.
        imaddr = 32'h3C; imreq = 1'b1;
        @(posedge clk); #1;
        imreq = 1'b0;
        chk("pre-reset busy", 32'(ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid-reset valid", 32'(valid), 32'h0);
        chk("mid-reset instr", instr, 32'h0);
        chk("mid-reset fault", 32'(fault), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        chk("no pulse after reset", 32'(pulses), 32'd0);
        chk("ready after reset", 32'(ready), 32'h1);
        chk("instr after reset", instr, 32'h0);
        do_fetch(32'h3C, lat, ins, flt, rdy_bad);
        chk("memory kept latency", 32'(lat), 32'd3);
        chk("memory kept word", ins, 32'h1234_5678);
        @(posedge clk); #1;

        // Zero wait states: valid in the cycle right after the WAIT edge.
        z_load_en = 1'b1; z_load_addr = 32'h4; z_load_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        z_load_en = 1'b0;
        z_imaddr = 32'h4; z_imreq = 1'b1;
        @(posedge clk); #1;
        z_imreq = 1'b0;
        z_imaddr = 32'h0;
        chk("ws0 busy", 32'(z_ready), 32'h0);
        chk("ws0 not yet valid", 32'(z_valid), 32'h0);
        @(posedge clk); #1;
        chk("ws0 valid", 32'(z_valid), 32'h1);
        chk("ws0 instr", z_instr, 32'h0BAD_F00D);
        chk("ws0 fault", 32'(z_fault), 32'h0);
        @(posedge clk); #1;
        chk("ws0 valid drop", 32'(z_valid), 32'h0);
        chk("ws0 ready again", 32'(z_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
